dsc_s2b_rx: RTL and testbench
=============================

Name: dsc_s2b_rx

Overview:
- Receive-side converter for deterministic stochastic computing (DSC) streams: takes one serial stochastic bitstream per frame and returns the binary count of ones.
- Sits downstream of the DSC multiplier and other SNG-driven units.
- Adds what a bare counter lacks: frame start/stop control, stall handling, full-scale representation, a latched result with a one-cycle done strobe.

Parameters:
- WIDTH, 8, SNG width of the upstream generators.
- FRAME_LOG2, 2*WIDTH, log2 of frame length in valid bits. Frame length L = 2^FRAME_LOG2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a new frame; honoured only in IDLE or DONE.
- sn_valid  input  1  qualifies sn_in; low = stall, bit ignored, no frame progress.
- sn_in  input  1  stochastic bit.
- abort  input  1  terminate current frame; no result is produced.
- z  output  FRAME_LOG2+1  latched ones-count of the last completed frame; range 0..L.
- done  output  1  one-cycle pulse when z updates.
- busy  output  1  high while in ACCUM.
- bit_idx  output  FRAME_LOG2  number of valid bits consumed in the current frame (debug/alignment).

Behaviour:
- Reset (async, any state): state=IDLE, z=0, done=0, busy=0, bit_idx=0, internal count=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 -> ACCUM next cycle; count=0, bit_idx=0.
  - sn_valid/sn_in are ignored in IDLE and in the start cycle itself. The first sampled bit is the cycle after start.
- ACCUM:
  - Each cycle with sn_valid=1: count += sn_in, bit_idx += 1.
  - sn_valid=0: hold count and bit_idx.
  - On the valid beat where bit_idx = L-1, the last bit is included, then:
    - z <= count + sn_in (FRAME_LOG2+1 bits, so an all-ones frame yields z=L with no wrap);
    - done=1 on the following cycle for exactly one cycle;
    - state -> DONE; bit_idx -> 0.
  - Latency: done asserts 1 cycle after the final valid bit is sampled.
- Abort in ACCUM:
  - abort=1 -> IDLE next cycle; count and bit_idx cleared; z retains its previous value; no done.
  - abort wins over a simultaneous final valid beat: no result.
  - abort in IDLE or DONE has no effect.
- DONE:
  - Holds z; busy=0.
  - start=1 -> ACCUM as from IDLE (back-to-back frames, one dead cycle between frames). z stays stable until the next frame completes.
  - Without start, stays in DONE.
- busy=1 exactly while in ACCUM. start while busy is ignored, including start coincident with the final bit.
- The counter never wraps inside a frame; the internal count width is FRAME_LOG2+1.
- The block keeps no other arithmetic state. For the 8b DSC multiplier, z = a*b when the frame spans 2^16 valid bits.

Test Plan:
- Reset mid-ACCUM with FRAME_LOG2=4: start, feed 5 ones, assert rst asynchronously between edges -> z=0, busy=0, done=0 immediately; the next start begins a fresh count.
- FRAME_LOG2=4, sn_valid=1 continuous, sn_in pattern 1010… (8 ones) -> done pulses once on cycle 17 after start, z=8, busy falls the same cycle done rises.
- FRAME_LOG2=4, all ones -> z=16 (bit 4 set, no wrap). All zeros -> z=0, done still pulses.
- Stall: FRAME_LOG2=4, sn_valid toggling 1/0 with sn_in=1 held high on invalid cycles -> z=16 after 32 cycles; invalid-cycle ones are not counted; bit_idx advances only on valid beats.
- Abort coincident with the 16th valid bit, previous z=5 -> no done, z stays 5, state IDLE. start during ACCUM is ignored (bit_idx unchanged).
- Defaults (WIDTH=8, FRAME_LOG2=16): drive from a DSC multiplier with a=200, b=150 -> z=30000 after 65536 valid bits. Back-to-back start from DONE with a=255, b=255 -> second z=65025, first z held until then.

Source files
------------

// File: rtl/dsc_s2b_rx.sv
// dsc_s2b_rx: framed stochastic-bitstream to binary ones-counter with stall, abort
// and a latched result plus a one-cycle done strobe.
module dsc_s2b_rx #(
  parameter int WIDTH      = 8,
  parameter int FRAME_LOG2 = 2*WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sn_valid,
  input  logic                  sn_in,
  input  logic                  abort,
  output logic [FRAME_LOG2:0]   z,
  output logic                  done,
  output logic                  busy,
  output logic [FRAME_LOG2-1:0] bit_idx
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                r_state;
  logic [FRAME_LOG2:0]   r_count;
  logic [FRAME_LOG2:0]   r_z;
  logic                  r_done;
  logic                  r_busy;
  logic [FRAME_LOG2-1:0] r_idx;
  logic [FRAME_LOG2:0]   w_sum;
  logic                  w_last;
  // One extra count bit lets an all-ones frame report exactly L.
  assign w_sum   = r_count + {{FRAME_LOG2{1'b0}}, sn_in};
  assign w_last  = sn_valid && (r_idx == {FRAME_LOG2{1'b1}});
  assign z       = r_z;
  assign done    = r_done;
  assign busy    = r_busy;
  assign bit_idx = r_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= ACCUM;
          r_busy  <= 1'b1;
          r_count <= '0;
          r_idx   <= '0;
        end
        ACCUM: if (abort) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_count <= '0;
          r_idx   <= '0;
        end else if (sn_valid) begin
          r_idx   <= r_idx + 1'b1;
          r_count <= w_last ? '0 : w_sum;
          if (w_last) begin
            r_z     <= w_sum;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_s2b_rx.sv
// tb_dsc_s2b_rx: directed and randomized frames against a popcount reference model.
module tb_dsc_s2b_rx;
  localparam int W  = 2;
  localparam int FL = 4;
  localparam int L  = 16;
  logic          clk = 1'b0;
  logic          rst, start, sn_valid, sn_in, abort;
  logic [FL:0]   z;
  logic          done, busy;
  logic [FL-1:0] bit_idx;
  int            errors = 0;
  int            checks = 0;
  int            last_z = 0;

  dsc_s2b_rx #(.WIDTH(W), .FRAME_LOG2(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .sn_valid(sn_valid), .sn_in(sn_in),
    .abort(abort), .z(z), .done(done), .busy(busy), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame with random stalls; expected z is the popcount of the valid bits.
  task automatic run_frame(input logic [L-1:0] bits, input int stall_pct, input bit start_mid);
    int exp = 0;
    for (int i = 0; i < L; i++) exp += int'(bits[i]);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("idx_start", bit_idx, 0);
    chk("z_held_start", z, last_z);
    for (int i = 0; i < L; i++) begin
      while (int'($urandom_range(99)) < stall_pct) begin
        sn_valid = 1'b0;
        sn_in    = 1'($urandom_range(1));
        step;
        chk("stall_idx", bit_idx, i);
        chk("stall_done", done, 0);
      end
      sn_valid = 1'b1;
      sn_in    = bits[i];
      start    = start_mid && (i == 5 || i == L-1);
      step;
      start = 1'b0;
      if (i < L-1) begin
        chk("idx", bit_idx, i+1);
        chk("no_done", done, 0);
        chk("busy", busy, 1);
        chk("z_held", z, last_z);
      end else begin
        chk("done", done, 1);
        chk("z", z, exp);
        chk("busy_fall", busy, 0);
        chk("idx_wrap", bit_idx, 0);
      end
    end
    sn_valid = 1'b0;
    step;
    chk("done_pulse", done, 0);
    chk("z_hold", z, exp);
    chk("busy_done", busy, 0);
    last_z = exp;
  endtask

  initial begin
    logic [L-1:0] bits;
    int a, b;
    rst = 1'b1; start = 1'b0; sn_valid = 1'b0; sn_in = 1'b0; abort = 1'b0;
    step;
    step;
    chk("rst_z", z, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", bit_idx, 0);
    rst = 1'b0;
    step;
    run_frame(16'h5555, 0, 1'b0);
    run_frame(16'hFFFF, 0, 1'b0);
    run_frame(16'h0000, 0, 1'b0);
    // Async reset mid-frame: outputs clear between clock edges.
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sn_valid = 1'b1; sn_in = 1'b1;
      step;
    end
    chk("pre_rst_idx", bit_idx, 5);
    #3 rst = 1'b1;
    #1;
    chk("arst_z", z, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", bit_idx, 0);
    #2 rst = 1'b0;
    sn_valid = 1'b0;
    last_z = 0;
    step;
    run_frame(16'h1234, 0, 1'b0);
    // Stall every other cycle with sn_in high while invalid.
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < L; i++) begin
      sn_valid = 1'b0; sn_in = 1'b1;
      step;
      chk("tog_stall_idx", bit_idx, i);
      sn_valid = 1'b1; sn_in = (i % 2 == 0);
      step;
    end
    chk("tog_done", done, 1);
    chk("tog_z", z, 8);
    sn_valid = 1'b0;
    step;
    last_z = 8;
    run_frame(16'hFFFF, 50, 1'b0);
    // Abort coincident with the final valid bit after a z=5 frame.
    run_frame(16'h001F, 0, 1'b1);
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < L-1; i++) begin
      sn_valid = 1'b1; sn_in = 1'b1;
      step;
    end
    abort = 1'b1; sn_valid = 1'b1; sn_in = 1'b1;
    step;
    abort = 1'b0; sn_valid = 1'b0;
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_z", z, 5);
    chk("abort_idx", bit_idx, 0);
    step;
    chk("abort_done2", done, 0);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_z", z, 5);
    for (int r = 0; r < 4; r++) begin
      bits = L'($urandom);
      run_frame(bits, 30, r[0]);
    end
    // Deterministic unary multiplier streams: frame of 2^(2W) bits yields a*b.
    for (int r = 0; r < 4; r++) begin
      a = int'($urandom_range(3));
      b = (r == 3) ? 3 : int'($urandom_range(3));
      if (r == 3) a = 3;
      for (int k = 0; k < L; k++) bits[k] = ((k % 4) < a) && ((k / 4) < b);
      run_frame(bits, 20, 1'b0);
      chk("dsc_z", z, a*b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
